sm_line_node_filter: RTL and testbench

SM_LINE_NODE_FILTER -- requirements
Module: sm_line_node_filter

---
 rtl/sm_line_pkg.sv | 17 +
 rtl/sm_frame_debounce.sv | 25 ++
 rtl/sm_line_node_filter.sv | 69 ++++++
 tb/tb_sm_line_node_filter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/sm_line_pkg.sv
// sm_line_pkg: shared channel/state encodings, pattern constants and steering-error map.
package sm_line_pkg;
  typedef enum logic [1:0] {CH_LEFT = 2'd0, CH_CENTRE = 2'd1, CH_RIGHT = 2'd2, CH_UNUSED = 2'd3} ch_e;
  typedef enum logic {COLLECT, EVAL} state_e;
  localparam logic [2:0] P_NODE = 3'b111;
  localparam logic [2:0] P_LOST = 3'b000;
  // Line lost keeps steering hard toward the side it was last seen on.
  function automatic logic signed [7:0] err_map(input logic [2:0] p, input logic signed [7:0] prev,
                                                input logic signed [7:0] s);
    return p == 3'b110 ? -s :
           p == 3'b100 ? -(8'sd2 * s) :
           p == 3'b011 ? s :
           p == 3'b001 ? 8'sd2 * s :
           p == P_LOST ? (prev < 0 ? -(8'sd3 * s) : prev > 0 ? 8'sd3 * s : 8'sd0) :
           8'sd0;
  endfunction
endpackage

// File: rtl/sm_frame_debounce.sv
// sm_frame_debounce: level flips only after N consecutive enabled samples disagree with it.
module sm_frame_debounce #(
  parameter int N = 4
) (
  input  logic clk_50,
  input  logic reset,
  input  logic sample,
  input  logic sample_en,
  output logic level
);
  localparam int CW = $clog2(N + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sample_en) begin
      if (sample == level) cnt <= '0;
      else if (cnt == CW'(N - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/sm_line_node_filter.sv
// sm_line_node_filter: gathers a 3-sensor frame, thresholds it, derives steering error and a debounced node flag.
module sm_line_node_filter
  import sm_line_pkg::*;
#(
  parameter logic [11:0] THRESHOLD     = 12'd1500,
  parameter int          STABLE_FRAMES = 4,
  parameter int          ERR_STEP      = 20,
  parameter int          FRAME_TIMEOUT = 100000
) (
  input  logic               clk_50,
  input  logic               reset,
  input  logic               adc_valid,
  input  logic [1:0]         adc_ch,
  input  logic [11:0]        adc_data,
  output logic               node_detected,
  output logic [2:0]         line_pattern,
  output logic signed [7:0]  error,
  output logic               frame_done
);
  localparam int TW = $clog2(FRAME_TIMEOUT + 1);
  state_e        state;
  logic [2:0]    bits, mask, onehot, nbits, nmask, pat;
  logic [TW-1:0] tcnt;
  logic          cap, done, tout;
  always_comb begin
    cap    = adc_valid && adc_ch != CH_UNUSED && state == COLLECT;
    onehot = cap ? 3'b001 << adc_ch : 3'b000;
    nmask  = mask | onehot;
    nbits  = (bits & ~onehot) | (adc_data >= THRESHOLD ? onehot : 3'b000);
    pat    = {nbits[0], nbits[1], nbits[2]};
    done   = cap && nmask == 3'b111;
    tout   = mask != 3'b000 && tcnt == TW'(FRAME_TIMEOUT - 1);
  end
  sm_frame_debounce #(.N(STABLE_FRAMES)) u_deb (
    .clk_50   (clk_50),
    .reset    (reset),
    .sample   (pat == P_NODE),
    .sample_en(done),
    .level    (node_detected)
  );
  // Results are registered on the completing edge so they are visible throughout the EVAL cycle.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state        <= COLLECT;
      bits         <= '0;
      mask         <= '0;
      tcnt         <= '0;
      line_pattern <= '0;
      error        <= '0;
      frame_done   <= 1'b0;
    end else if (state == EVAL) begin
      state      <= COLLECT;
      mask       <= '0;
      tcnt       <= '0;
      frame_done <= 1'b0;
    end else if (done) begin
      state        <= EVAL;
      bits         <= nbits;
      mask         <= nmask;
      line_pattern <= pat;
      error        <= err_map(pat, error, 8'(ERR_STEP));
      frame_done   <= 1'b1;
    end else begin
      bits <= nbits;
      mask <= tout ? onehot : nmask;
      tcnt <= (tout || mask == 3'b000) ? '0 : tcnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_sm_line_node_filter.sv
// tb_sm_line_node_filter: directed frames with a scoreboard queue checked by an independent frame_done monitor.
module tb_sm_line_node_filter;
  typedef struct {
    logic [2:0] p;
    int         e;
    logic       n;
  } exp_t;
  logic              clk_50 = 1'b0;
  logic              reset = 1'b1;
  logic              adc_valid = 1'b0;
  logic [1:0]        adc_ch = 2'd0;
  logic [11:0]       adc_data = 12'd0;
  logic              node_detected;
  logic [2:0]        line_pattern;
  logic signed [7:0] error;
  logic              frame_done;
  exp_t              q[$];
  exp_t              x;
  logic              v_edge = 1'b0;
  int                total = 0;
  int                bad = 0;
  sm_line_node_filter #(.FRAME_TIMEOUT(200)) dut (
    .clk_50       (clk_50),
    .reset        (reset),
    .adc_valid    (adc_valid),
    .adc_ch       (adc_ch),
    .adc_data     (adc_data),
    .node_detected(node_detected),
    .line_pattern (line_pattern),
    .error        (error),
    .frame_done   (frame_done)
  );
  always #10 clk_50 = ~clk_50;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask
  always @(posedge clk_50) v_edge = adc_valid;
  always @(negedge clk_50) begin
    if (frame_done) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_frame_done got pattern=%b expected no frame", line_pattern);
      end else begin
        x = q.pop_front();
        chk("pattern", int'(line_pattern), int'(x.p));
        chk("error", int'(error), x.e);
        chk("node", int'(node_detected), int'(x.n));
        chk("latency", int'(v_edge), 1);
      end
    end
  end
  task automatic send(input logic [1:0] ch, input logic [11:0] d);
    @(negedge clk_50);
    adc_valid = 1'b1;
    adc_ch    = ch;
    adc_data  = d;
    @(negedge clk_50);
    adc_valid = 1'b0;
  endtask
  task automatic frame(input logic [11:0] d0, d1, d2, input logic [2:0] p, input int e, input logic n);
    send(2'd0, d0);
    send(2'd1, d1);
    q.push_back('{p, e, n});
    send(2'd2, d2);
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk_50);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    idle(3);
    reset = 1'b0;
    idle(1);
    chk("rst_node", int'(node_detected), 0);
    chk("rst_pattern", int'(line_pattern), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    frame(2000, 2000, 100, 3'b110, -20, 0);
    for (int i = 0; i < 3; i++) frame(3000, 3000, 3000, 3'b111, 0, 0);
    frame(100, 2000, 100, 3'b010, 0, 0);
    for (int i = 0; i < 4; i++) frame(3000, 3000, 3000, 3'b111, 0, i == 3);
    frame(2000, 100, 100, 3'b100, -40, 1);
    frame(100, 100, 100, 3'b000, -60, 1);
    frame(100, 100, 2000, 3'b001, 40, 1);
    frame(100, 100, 100, 3'b000, 60, 0);
    for (int i = 0; i < 4; i++) frame(3000, 3000, 3000, 3'b111, 0, i == 3);
    chk("pre_rst_node", int'(node_detected), 1);
    send(2'd0, 3000);
    send(2'd1, 3000);
    @(negedge clk_50);
    adc_valid = 1'b1;
    adc_ch    = 2'd2;
    adc_data  = 3000;
    @(posedge clk_50);
    #3 reset = 1'b1;
    adc_valid = 1'b0;
    #1;
    chk("async_rst_node", int'(node_detected), 0);
    chk("async_rst_pattern", int'(line_pattern), 0);
    chk("async_rst_error", int'(error), 0);
    chk("async_rst_frame_done", int'(frame_done), 0);
    @(negedge clk_50);
    reset = 1'b0;
    idle(2);
    frame(100, 100, 100, 3'b000, 0, 0);
    send(2'd0, 2000);
    send(2'd0, 100);
    send(2'd3, 4095);
    send(2'd1, 2000);
    q.push_back('{3'b011, 20, 1'b0});
    send(2'd2, 2000);
    send(2'd0, 2000);
    send(2'd1, 2000);
    idle(250);
    chk("timeout_pattern", int'(line_pattern), 3'b011);
    chk("timeout_error", int'(error), 20);
    chk("timeout_node", int'(node_detected), 0);
    send(2'd2, 2000);
    idle(10);
    send(2'd0, 100);
    q.push_back('{3'b001, 40, 1'b0});
    send(2'd1, 100);
    idle(5);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
